alu_operand_stage: RTL

Registered operand-select stage between ID and EX of the pipelined RISC-V core.
- Resolves rs1/rs2 through a priority forwarding network of NUM_FWD later-stage sources.
- Selects op1 from REG/PC/ZERO and op2 from REG/IMM/FOUR.
- Registers op1, op2 and store data behind a valid/ready handshake.
- Detects load-use hazards and back-pressures ID.

---
 rtl/alu_operand_pkg.sv | 27 ++
 rtl/alu_operand_stage_fwd_select.sv | 37 +++
 rtl/alu_operand_stage.sv | 138 +++++++++++++
 3 files changed

// File: rtl/alu_operand_pkg.sv
// Shared types for the ALU operand-select stage.
// Operand select encodings, the +4 constant and the forwarding result bundle.
package alu_operand_pkg;

  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] OP2_FOUR = 32'd4;

  typedef enum logic [1:0] {
    OP1_SEL_REG  = 2'd0,
    OP1_SEL_PC   = 2'd1,
    OP1_SEL_ZERO = 2'd2
  } op1_sel_e;

  typedef enum logic [1:0] {
    OP2_SEL_REG  = 2'd0,
    OP2_SEL_IMM  = 2'd1,
    OP2_SEL_FOUR = 2'd2
  } op2_sel_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              hit;
    logic              pending;
  } fwd_result_t;

endpackage

// File: rtl/alu_operand_stage_fwd_select.sv
// Priority forwarding match for one source operand.
// Source 0 is the youngest result and wins over all older ones.
module fwd_select
  import alu_operand_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int NUM_FWD    = 2
) (
  input  logic [REG_ADDR_W-1:0]         addr,
  input  logic [XLEN-1:0]               rf_data,
  input  logic [NUM_FWD-1:0]            fwd_valid,
  input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_rd,
  input  logic [NUM_FWD*XLEN-1:0]       fwd_data,
  input  logic [NUM_FWD-1:0]            fwd_data_rdy,
  output fwd_result_t                   res
);

  // Scan oldest to youngest so the lowest matching index is applied last.
  always_comb begin
    res      = '0;
    res.data = rf_data;
    if (addr == '0) begin
      res.data = '0;
    end else begin
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
        if (fwd_valid[i] &&
            fwd_rd[i*REG_ADDR_W +: REG_ADDR_W] == addr) begin
          res.data    = fwd_data[i*XLEN +: XLEN];
          res.hit     = 1'b1;
          res.pending = !fwd_data_rdy[i];
        end
      end
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Registered ID/EX operand select with forwarding and load-use stall.
// Optional perf counters enabled by ALU_OPERAND_STAGE_PERF_EN.
module alu_operand_stage
  import alu_operand_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int NUM_FWD    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [REG_ADDR_W-1:0]         rs1_addr,
  input  logic [REG_ADDR_W-1:0]         rs2_addr,
  input  logic [XLEN-1:0]               rs1_data,
  input  logic [XLEN-1:0]               rs2_data,
  input  logic [XLEN-1:0]               imm,
  input  logic [XLEN-1:0]               pc,
  input  logic [1:0]                    op1_sel,
  input  logic [1:0]                    op2_sel,
  input  logic                          store_en,
  input  logic [NUM_FWD-1:0]            fwd_valid,
  input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_rd,
  input  logic [NUM_FWD*XLEN-1:0]       fwd_data,
  input  logic [NUM_FWD-1:0]            fwd_data_rdy,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [XLEN-1:0]               op1,
  output logic [XLEN-1:0]               op2,
  output logic [XLEN-1:0]               store_data,
`ifdef ALU_OPERAND_STAGE_PERF_EN
  output logic [31:0]                   fwd_hit_cnt,
  output logic [31:0]                   stall_cnt,
`endif
  output logic                          hazard_stall
);

  fwd_result_t r1, r2;
  logic        use1, use2;
  logic        capture;
  logic [XLEN-1:0] op1_nxt, op2_nxt;

  fwd_select #(
    .XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .NUM_FWD(NUM_FWD)
  ) u_fwd1 (
    .addr(rs1_addr), .rf_data(rs1_data),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_data(fwd_data), .fwd_data_rdy(fwd_data_rdy),
    .res(r1)
  );

  fwd_select #(
    .XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .NUM_FWD(NUM_FWD)
  ) u_fwd2 (
    .addr(rs2_addr), .rf_data(rs2_data),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_data(fwd_data), .fwd_data_rdy(fwd_data_rdy),
    .res(r2)
  );

  assign use1 = (op1_sel == OP1_SEL_REG);
  assign use2 = (op2_sel == OP2_SEL_REG) || store_en;

  assign hazard_stall = in_valid &&
                        ((use1 && r1.pending) || (use2 && r2.pending));

  assign in_ready = !flush && !hazard_stall &&
                    (!out_valid || out_ready);

  assign capture = in_valid && in_ready;

  // Operand muxes; the unused encoding 3 falls through to zero.
  always_comb begin
    op1_nxt = '0;
    op2_nxt = '0;
    case (op1_sel)
      OP1_SEL_REG: op1_nxt = r1.data;
      OP1_SEL_PC:  op1_nxt = pc;
      default:     op1_nxt = '0;
    endcase
    case (op2_sel)
      OP2_SEL_REG:  op2_nxt = r2.data;
      OP2_SEL_IMM:  op2_nxt = imm;
      OP2_SEL_FOUR: op2_nxt = OP2_FOUR;
      default:      op2_nxt = '0;
    endcase
  end

  // Output valid: flush kills, capture sets, dispatch clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Operand registers load only on capture and hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op1        <= '0;
      op2        <= '0;
      store_data <= '0;
    end else if (capture) begin
      op1        <= op1_nxt;
      op2        <= op2_nxt;
      store_data <= r2.data;
    end
  end

`ifdef ALU_OPERAND_STAGE_PERF_EN
  logic fwd_used;

  assign fwd_used = (use1 && r1.hit) || (use2 && r2.hit);

  // Saturating event counters for forwarded captures and stall cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_hit_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (capture && fwd_used && fwd_hit_cnt != '1) begin
        fwd_hit_cnt <= fwd_hit_cnt + 32'd1;
      end
      if (hazard_stall && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
